// File: rtl/rackbus_pkg.sv
// Shared rackbus definitions for the TURFIO-side sequencer and the SURF-side receiver.
// Optional feature macro used by the sequencer: RACKBUS_RETRAIN_EN.
package rackbus_pkg;

    typedef enum logic [2:0] {
        S_WAITLOCK = 3'd0,
        S_CLKRST   = 3'd1,
        S_IORST    = 3'd2,
        S_TRAIN    = 3'd3,
        S_RUN      = 3'd4
    } rackbus_seq_state_t;

    localparam int unsigned RACKBUS_WORD_W = 6;
    localparam int unsigned RACKBUS_CMD_W  = 24;
    localparam int unsigned RACKBUS_BEATS  = 4;

    localparam logic [RACKBUS_WORD_W-1:0] RACKBUS_TRAIN_PATTERN = 6'b011001;
    localparam logic [RACKBUS_WORD_W-1:0] RACKBUS_IDLE_PATTERN  = 6'b000000;

    // Beat 0 is the most significant 6 bits of the command.
    function automatic logic [RACKBUS_WORD_W-1:0] rackbus_beat_word(
        input logic [RACKBUS_CMD_W-1:0] cmd,
        input logic [1:0]               idx
    );
        logic [RACKBUS_WORD_W-1:0] w;
        case (idx)
            2'd0:    w = cmd[23:18];
            2'd1:    w = cmd[17:12];
            2'd2:    w = cmd[11:6];
            default: w = cmd[5:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rackbus_cmd_serializer.sv
// Command holding register and beat counter; produces next-cycle word/ready for the sequencer
// to register. Used by rackbus_out_sequencer (optional macro RACKBUS_RETRAIN_EN drives 'stop').
module rackbus_cmd_serializer
    import rackbus_pkg::*;
#(
    parameter logic [5:0] IDLE_PATTERN = RACKBUS_IDLE_PATTERN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stop,
    input  logic [23:0] cmd,
    input  logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  word_next,
    output logic        ready_next,
    output logic        busy_next
);

    logic [23:0] hold, hold_n;
    logic [1:0]  beat, beat_n;
    logic        active, active_n;
    logic        accept;

    assign accept = cmd_valid && cmd_ready && run;

    // busy_next deliberately ignores 'run' so the sequencer FSM can use it without a loop.
    assign busy_next = (cmd_valid && cmd_ready) || (active && (beat != 2'd3));

    always_comb begin
        hold_n   = hold;
        beat_n   = beat;
        active_n = active;
        if (!run) begin
            active_n = 1'b0;
            beat_n   = 2'd0;
        end else if (accept) begin
            hold_n   = cmd;
            active_n = 1'b1;
            beat_n   = 2'd0;
        end else if (active && (beat != 2'd3)) begin
            beat_n = beat + 2'd1;
        end else begin
            active_n = 1'b0;
            beat_n   = 2'd0;
        end
    end

    always_comb begin
        word_next  = active_n ? rackbus_beat_word(hold_n, beat_n) : IDLE_PATTERN;
        ready_next = run && !stop && (!active_n || (beat_n == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold   <= '0;
            beat   <= '0;
            active <= 1'b0;
        end else begin
            hold   <= hold_n;
            beat   <= beat_n;
            active <= active_n;
        end
    end

endmodule

// File: rtl/rackbus_out_sequencer.sv
// TURFIO->SURF rackbus output bring-up sequencer: OSERDES reset release, training, command beats.
// Define RACKBUS_RETRAIN_EN to add the retrain_i port and in-band retraining from S_RUN.
module rackbus_out_sequencer
    import rackbus_pkg::*;
#(
    parameter int unsigned CLK_RST_CYCLES = 16,
    parameter int unsigned IO_RST_CYCLES  = 16,
    parameter int unsigned TRAIN_CYCLES   = 1024,
    parameter logic [5:0]  TRAIN_PATTERN  = RACKBUS_TRAIN_PATTERN,
    parameter logic [5:0]  IDLE_PATTERN   = RACKBUS_IDLE_PATTERN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        locked_i,
    input  logic [23:0] cmd_i,
    input  logic        cmd_valid_i,
`ifdef RACKBUS_RETRAIN_EN
    input  logic        retrain_i,
`endif
    output logic        cmd_ready_o,
    output logic [5:0]  data_o,
    output logic        clk_reset_o,
    output logic        io_reset_o,
    output logic        link_ready_o
);

    localparam int unsigned MAX_A   = (CLK_RST_CYCLES > IO_RST_CYCLES) ? CLK_RST_CYCLES : IO_RST_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > TRAIN_CYCLES) ? MAX_A : TRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    rackbus_seq_state_t state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               run, retrain_req;
    logic [5:0]         ser_word_next;
    logic               ser_ready_next, ser_busy_next;

`ifdef RACKBUS_RETRAIN_EN
    logic retrain_pend;
    assign retrain_req = (state == S_RUN) && (retrain_i || retrain_pend);
`else
    assign retrain_req = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_WAITLOCK: if (locked_i) state_n = S_CLKRST;
            S_CLKRST:   if (cnt == '0) state_n = S_IORST;
            S_IORST:    if (cnt == '0) state_n = S_TRAIN;
            S_TRAIN:    if (cnt == '0) state_n = S_RUN;
            S_RUN:      if (retrain_req && !ser_busy_next) state_n = S_TRAIN;
            default:    state_n = S_WAITLOCK;
        endcase
        if ((state != S_WAITLOCK) && !locked_i) state_n = S_WAITLOCK;
        if (reset) state_n = S_WAITLOCK;
    end

    always_comb begin
        cnt_n = cnt;
        if (state_n != state) begin
            case (state_n)
                S_CLKRST: cnt_n = CNT_W'(CLK_RST_CYCLES - 1);
                S_IORST:  cnt_n = CNT_W'(IO_RST_CYCLES - 1);
                S_TRAIN:  cnt_n = CNT_W'(TRAIN_CYCLES - 1);
                default:  cnt_n = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end
    end

    assign run = (state_n == S_RUN);

    rackbus_cmd_serializer #(
        .IDLE_PATTERN (IDLE_PATTERN)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .stop       (retrain_req),
        .cmd        (cmd_i),
        .cmd_valid  (cmd_valid_i),
        .cmd_ready  (cmd_ready_o),
        .word_next  (ser_word_next),
        .ready_next (ser_ready_next),
        .busy_next  (ser_busy_next)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_WAITLOCK;
            cnt          <= '0;
            clk_reset_o  <= 1'b1;
            io_reset_o   <= 1'b1;
            data_o       <= '0;
            cmd_ready_o  <= 1'b0;
            link_ready_o <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            clk_reset_o  <= (state_n == S_WAITLOCK) || (state_n == S_CLKRST);
            io_reset_o   <= (state_n == S_WAITLOCK) || (state_n == S_CLKRST) || (state_n == S_IORST);
            cmd_ready_o  <= ser_ready_next;
            link_ready_o <= run && !retrain_req;
            if (state_n == S_TRAIN)
                data_o <= TRAIN_PATTERN;
            else if (state_n == S_RUN)
                data_o <= ser_word_next;
            else
                data_o <= '0;
        end
    end

`ifdef RACKBUS_RETRAIN_EN
    always_ff @(posedge clk) begin
        if (reset)
            retrain_pend <= 1'b0;
        else
            retrain_pend <= retrain_req && (state_n == S_RUN);
    end
`endif

endmodule
